// File: rtl/axi4_sram_slave_if.sv
// AXI4 bus bundle (AW, W, B, AR, R channels, 32-bit data) used by axi4_sram_slave.
interface axi4_ifc #(parameter int IWIDTH = 5);
    logic [IWIDTH-1:0] awid;
    logic [31:0]       awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [IWIDTH-1:0] bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [IWIDTH-1:0] arid;
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [IWIDTH-1:0] rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 INCR-burst slave onto a 1-cycle-latency SRAM; independent write and read FSMs.
// Optional AXI4_SRAM_BURST_CHECK_EN: non-INCR or non-4-byte bursts answer SLVERR without touching memory.
module axi4_sram_slave #(
    parameter int IWIDTH = 5,
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              reset,
    axi4_ifc.slave            s,
    output logic              o_we,
    output logic [AWIDTH-1:0] o_waddr,
    output logic [31:0]       o_wdata,
    output logic [AWIDTH-1:0] o_raddr,
    input  logic [31:0]       i_rdata
);
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_e;

    w_state_e          w_state_q, w_state_d;
    logic              awready_q, awready_d;
    logic [AWIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [IWIDTH-1:0] wid_q, wid_d;
    logic              werr_q, werr_d;
    logic              we_s, aw_bad_s;

    r_state_e          r_state_q, r_state_d;
    logic              arready_q, arready_d;
    logic [AWIDTH-1:0] raddr_q, raddr_d, raddr_s;
    logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [IWIDTH-1:0] rid_q, rid_d;
    logic              rerr_q, rerr_d;
    logic              rlast_s, ar_bad_s;

`ifdef AXI4_SRAM_BURST_CHECK_EN
    assign aw_bad_s = (s.awsize != 3'd2) || (s.awburst != 2'd1);
    assign ar_bad_s = (s.arsize != 3'd2) || (s.arburst != 2'd1);
`else
    assign aw_bad_s = 1'b0;
    assign ar_bad_s = 1'b0;
`endif

    logic unused_s;
    assign unused_s = ^{s.awaddr[31:AWIDTH+2], s.awaddr[1:0], s.araddr[31:AWIDTH+2], s.araddr[1:0],
                        s.awsize, s.awburst, s.awlock, s.awcache, s.awprot,
                        s.arsize, s.arburst, s.arlock, s.arcache, s.arprot, s.wstrb};

    // Write FSM: latch AW, stream W beats straight to the SRAM port, then answer on B.
    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        wid_d     = wid_q;
        werr_d    = werr_q;
        we_s      = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s.awvalid && awready_q) begin
                    wid_d     = s.awid;
                    waddr_d   = s.awaddr[AWIDTH+1:2];
                    wlen_d    = s.awlen;
                    wcnt_d    = 8'd0;
                    werr_d    = aw_bad_s;
                    w_state_d = W_DATA;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_DATA: begin
                if (s.wvalid) begin
                    we_s    = !werr_q;
                    waddr_d = waddr_q + AWIDTH'(1);
                    wcnt_d  = wcnt_q + 8'd1;
                    // The beat count is authoritative; an early wlast also closes the burst.
                    if (s.wlast || (wcnt_q == wlen_q)) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_state_d = W_DATA;
                    end
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (s.bready) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
    end

    // Read FSM: address goes out combinationally so the SRAM word is ready one cycle later.
    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        raddr_s   = raddr_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rid_d     = rid_q;
        rerr_d    = rerr_q;
        rlast_s   = (r_state_q == R_DATA) && (rcnt_q == rlen_q);
        case (r_state_q)
            R_IDLE: begin
                if (s.arvalid && arready_q) begin
                    rid_d     = s.arid;
                    raddr_d   = s.araddr[AWIDTH+1:2];
                    raddr_s   = s.araddr[AWIDTH+1:2];
                    rlen_d    = s.arlen;
                    rcnt_d    = 8'd0;
                    rerr_d    = ar_bad_s;
                    r_state_d = R_WAIT;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_WAIT: r_state_d = R_DATA;
            R_DATA: begin
                if (s.rready && rlast_s) begin
                    r_state_d = R_IDLE;
                end else if (s.rready) begin
                    raddr_d = raddr_q + AWIDTH'(1);
                    raddr_s = raddr_q + AWIDTH'(1);
                    rcnt_d  = rcnt_q + 8'd1;
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    // State and burst-context registers for both channels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            waddr_q   <= '0;
            wlen_q    <= 8'd0;
            wcnt_q    <= 8'd0;
            wid_q     <= '0;
            werr_q    <= 1'b0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            raddr_q   <= '0;
            rlen_q    <= 8'd0;
            rcnt_q    <= 8'd0;
            rid_q     <= '0;
            rerr_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            wid_q     <= wid_d;
            werr_q    <= werr_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rid_q     <= rid_d;
            rerr_q    <= rerr_d;
        end
    end

    assign s.awready = awready_q;
    assign s.wready  = (w_state_q == W_DATA);
    assign s.bvalid  = (w_state_q == W_RESP);
    assign s.bid     = wid_q;
    assign s.bresp   = werr_q ? RESP_SLVERR : RESP_OKAY;
    assign o_we      = we_s;
    assign o_waddr   = waddr_q;
    assign o_wdata   = s.wdata;

    assign s.arready = arready_q;
    assign s.rvalid  = (r_state_q == R_DATA);
    assign s.rdata   = ((r_state_q == R_DATA) && !rerr_q) ? i_rdata : 32'd0;
    assign s.rid     = rid_q;
    assign s.rresp   = rerr_q ? RESP_SLVERR : RESP_OKAY;
    assign s.rlast   = rlast_s;
    assign o_raddr   = raddr_s;
endmodule

// File: tb/tb_axi4_sram_slave.sv
// Scoreboard bench for axi4_sram_slave: driver tasks push expectations, a negedge monitor pops and compares.
module tb_axi4_sram_slave;
    logic        clk;
    logic        reset;
    logic        o_we;
    logic [11:0] o_waddr;
    logic [31:0] o_wdata;
    logic [11:0] o_raddr;
    logic [31:0] i_rdata;

    axi4_ifc #(.IWIDTH(5)) axi ();

    axi4_sram_slave #(.IWIDTH(5), .AWIDTH(12)) dut (
        .clk     (clk),
        .reset   (reset),
        .s       (axi),
        .o_we    (o_we),
        .o_waddr (o_waddr),
        .o_wdata (o_wdata),
        .o_raddr (o_raddr),
        .i_rdata (i_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (o_we) mem[o_waddr] <= o_wdata;
        i_rdata <= mem[o_raddr];
    end

    typedef struct packed { logic [11:0] addr; logic [31:0] data; } wexp_t;
    typedef struct packed { logic [4:0] id; logic [1:0] resp; } bexp_t;
    typedef struct packed { logic [31:0] data; logic last; logic [4:0] id; logic [1:0] resp; } rexp_t;

    wexp_t wq[$];
    bexp_t bq[$];
    rexp_t rq[$];
    wexp_t w_e;
    bexp_t b_e;
    rexp_t r_e;
    logic [31:0] ref_mem [0:4095];
    int errors = 0;
    int checks = 0;
    logic hold_v;
    logic [31:0] hold_d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit bad_burst(input logic [2:0] size, input logic [1:0] burst);
`ifdef AXI4_SRAM_BURST_CHECK_EN
        return (size != 3'd2) || (burst != 2'd1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_write(input logic [4:0] id, input logic [31:0] addr, input int len, input int nbeats,
                            input logic [2:0] size, input logic [1:0] burst, input bit gaps,
                            input int abort_at, input logic [31:0] base);
        bit err;
        int eff;
        int n;
        logic [11:0] w;
        err = bad_burst(size, burst);
        eff = (nbeats < len + 1) ? nbeats : len + 1;
        if (abort_at < 0) bq.push_back('{id: id, resp: err ? 2'd2 : 2'd0});
        axi.awvalid = 1'b1; axi.awid = id; axi.awaddr = addr; axi.awlen = 8'(len);
        axi.awsize = size; axi.awburst = burst;
        n = 0;
        @(negedge clk);
        while (!axi.awready && n < 50) begin @(negedge clk); n++; end
        chk("aw_ready", 32'(axi.awready), 32'd1);
        step();
        axi.awvalid = 1'b0;
        for (int i = 0; i < eff; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                axi.wvalid = 1'b0;
                repeat ($urandom_range(1, 2)) step();
            end
            axi.wvalid = 1'b1; axi.wdata = base + 32'(i); axi.wlast = (i == nbeats - 1);
            if (i == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                chk("abort_we", 32'(o_we), 32'd0);
                chk("abort_wready", 32'(axi.wready), 32'd0);
                step();
                reset = 1'b0; axi.wvalid = 1'b0; axi.wlast = 1'b0;
                @(negedge clk);
                chk("abort_no_b", 32'(axi.bvalid), 32'd0);
                step();
                return;
            end
            w = 12'(addr[13:2] + 12'(i));
            if (!err) begin
                wq.push_back('{addr: w, data: base + 32'(i)});
                ref_mem[w] = base + 32'(i);
            end
            n = 0;
            @(negedge clk);
            while (!axi.wready && n < 50) begin @(negedge clk); n++; end
            chk("w_ready", 32'(axi.wready), 32'd1);
            step();
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        @(negedge clk);
        chk("b_latency", 32'(axi.bvalid), 32'd1);
        repeat ($urandom_range(0, 2)) step();
        step();
        axi.bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!axi.bvalid && n < 50) begin @(negedge clk); n++; end
        chk("b_valid", 32'(axi.bvalid), 32'd1);
        step();
        axi.bready = 1'b0;
    endtask

    // mode 0: rready held high, 1: toggled every cycle, 2: random.
    task automatic do_read(input logic [4:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
        bit err;
        int n;
        int got;
        int k;
        logic [11:0] w;
        err = bad_burst(size, burst);
        for (int i = 0; i <= len; i++) begin
            w = 12'(addr[13:2] + 12'(i));
            rq.push_back('{data: err ? 32'd0 : ref_mem[w], last: (i == len), id: id, resp: err ? 2'd2 : 2'd0});
        end
        axi.arvalid = 1'b1; axi.arid = id; axi.araddr = addr; axi.arlen = 8'(len);
        axi.arsize = size; axi.arburst = burst;
        n = 0;
        @(negedge clk);
        while (!axi.arready && n < 50) begin @(negedge clk); n++; end
        chk("ar_ready", 32'(axi.arready), 32'd1);
        step();
        axi.arvalid = 1'b0;
        axi.rready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("r_wait_latency", 32'(axi.rvalid), 32'd0);
        step();
        got = 0;
        k = 0;
        while (got <= len && k < 3000) begin
            @(negedge clk);
            if (k == 0) chk("r_first_latency", 32'(axi.rvalid), 32'd1);
            if (axi.rvalid && axi.rready) got++;
            step();
            k++;
            case (mode)
                0:       axi.rready = 1'b1;
                1:       axi.rready = (k % 2 == 0);
                default: axi.rready = 1'($urandom_range(0, 1));
            endcase
        end
        axi.rready = 1'b0;
        chk("r_beats", 32'(got), 32'(len + 1));
    endtask

    // Scoreboard monitor: every SRAM write, B handshake and R handshake consumes one expectation.
    initial begin
        hold_v = 1'b0;
        hold_d = 32'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_v = 1'b0;
            end else begin
                if (o_we) begin
                    if (wq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL w_unexpected: got write to %h expected none", o_waddr);
                    end else begin
                        w_e = wq.pop_front();
                        chk("w_addr", 32'(o_waddr), 32'(w_e.addr));
                        chk("w_data", o_wdata, w_e.data);
                    end
                end
                if (axi.bvalid && axi.bready) begin
                    if (bq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL b_unexpected: got bid %h expected none", axi.bid);
                    end else begin
                        b_e = bq.pop_front();
                        chk("b_id", 32'(axi.bid), 32'(b_e.id));
                        chk("b_resp", 32'(axi.bresp), 32'(b_e.resp));
                    end
                end
                if (axi.rvalid && hold_v) chk("r_stable", axi.rdata, hold_d);
                if (axi.rvalid && axi.rready) begin
                    if (rq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL r_unexpected: got rdata %h expected none", axi.rdata);
                    end else begin
                        r_e = rq.pop_front();
                        chk("r_data", axi.rdata, r_e.data);
                        chk("r_last", 32'(axi.rlast), 32'(r_e.last));
                        chk("r_id", 32'(axi.rid), 32'(r_e.id));
                        chk("r_resp", 32'(axi.rresp), 32'(r_e.resp));
                    end
                end
                hold_v = axi.rvalid && !axi.rready;
                hold_d = axi.rdata;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish within time bound");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        axi.awvalid = 1'b0; axi.awid = 5'd0; axi.awaddr = 32'd0; axi.awlen = 8'd0; axi.awsize = 3'd2;
        axi.awburst = 2'd1; axi.awlock = 1'b0; axi.awcache = 4'd0; axi.awprot = 3'd0;
        axi.wvalid = 1'b0; axi.wdata = 32'd0; axi.wstrb = 4'hF; axi.wlast = 1'b0; axi.bready = 1'b0;
        axi.arvalid = 1'b0; axi.arid = 5'd0; axi.araddr = 32'd0; axi.arlen = 8'd0; axi.arsize = 3'd2;
        axi.arburst = 2'd1; axi.arlock = 1'b0; axi.arcache = 4'd0; axi.arprot = 3'd0; axi.rready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_awready", 32'(axi.awready), 32'd0);
        chk("rst_arready", 32'(axi.arready), 32'd0);
        chk("rst_valids", 32'({axi.wready, axi.bvalid, axi.rvalid, axi.rlast, o_we}), 32'd0);
        chk("rst_addrs", 32'({o_waddr, o_raddr}), 32'd0);
        chk("rst_ids", 32'({axi.bid, axi.rid, axi.bresp, axi.rresp}), 32'd0);
        chk("rst_rdata", axi.rdata, 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("awready_before_edge", 32'(axi.awready), 32'd0);
        @(negedge clk);
        chk("awready_after_edge", 32'(axi.awready), 32'd1);
        chk("arready_after_edge", 32'(axi.arready), 32'd1);
        chk("idle_no_we", 32'(o_we), 32'd0);
        step();

        do_write(5'd3, 32'h0000_0000, 7, 8, 3'd2, 2'd1, 1'b0, -1, 32'h1111_0000);
        do_read(5'd5, 32'h0000_0000, 7, 3'd2, 2'd1, 0);
        do_read(5'd5, 32'h0000_0000, 7, 3'd2, 2'd1, 1);
        do_write(5'd1, 32'h0000_3FFC, 1, 2, 3'd2, 2'd1, 1'b0, -1, 32'hCAFE_0000);
        do_read(5'd2, 32'hFFFF_FFFC, 1, 3'd2, 2'd1, 2);
        do_write(5'd4, 32'h0000_0300, 3, 2, 3'd2, 2'd1, 1'b0, -1, 32'h0E00_0000);
        do_write(5'd6, 32'h0000_0400, 1, 4, 3'd2, 2'd1, 1'b0, -1, 32'h0F00_0000);
        do_read(5'd6, 32'h0000_0300, 1, 3'd2, 2'd1, 0);
        do_read(5'd6, 32'h0000_0400, 1, 3'd2, 2'd1, 0);
        do_write(5'd7, 32'h0000_0200, 7, 8, 3'd2, 2'd1, 1'b0, 3, 32'hA0A0_0000);
        do_read(5'd8, 32'h0000_0200, 2, 3'd2, 2'd1, 1);
        do_write(5'd11, 32'h0000_3E00, 255, 256, 3'd2, 2'd1, 1'b1, -1, 32'h7700_0000);
        do_read(5'd12, 32'h0000_3E00, 255, 3'd2, 2'd1, 2);

        for (int t = 0; t < 10; t++) begin
            logic [31:0] a;
            int l;
            a = $urandom;
            l = $urandom_range(0, 15);
            do_write(5'($urandom), a, l, l + 1, 3'd2, 2'd1, 1'b1, -1, $urandom);
            do_read(5'($urandom), a ^ ($urandom & 32'hFFFF_C003), l, 3'd2, 2'd1, t % 3);
        end

`ifdef AXI4_SRAM_BURST_CHECK_EN
        do_read(5'd9, 32'h0000_0000, 1, 3'd2, 2'd0, 0);
        do_write(5'd10, 32'h0000_0040, 3, 4, 3'd2, 2'd1, 1'b0, -1, 32'h5000_0000);
        do_write(5'd10, 32'h0000_0040, 3, 4, 3'd1, 2'd1, 1'b0, -1, 32'hDEAD_0000);
        do_read(5'd13, 32'h0000_0040, 3, 3'd2, 2'd1, 0);
`endif

        repeat (5) step();
        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("bq_drained", 32'(bq.size()), 32'd0);
        chk("rq_drained", 32'(rq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
